// File: rtl/bmu_op_queue.sv
// ---------------------------------------------------------------------------
// bmu_op_queue
//   Bit-manipulation execution unit with a buffered result path.
//   One request is accepted per cycle. Its result is computed combinationally
//   when it is accepted, and {error,result} is written into a DEPTH-entry FIFO.
//   A valid/ready consumer drains that FIFO. Nothing bypasses the FIFO, so a
//   result appears on the output one cycle after it is accepted.
//
// Parameters
//   XLEN   operand/result width (power of 2, >= 8)
//   DEPTH  result FIFO entries (>= 2)
//   OP_W   opcode width; opcodes above 15 are illegal
//
// Ports
//   clk            clock, rising edge
//   rst_l          synchronous reset, active-high (1 = reset)
//   valid_in       request valid
//   ready_out      request accepted when valid_in && ready_out
//   op_in          opcode
//   csr_ren_in     CSR read; forwards csr_rddata_in and ignores op_in
//   csr_rddata_in  CSR read data
//   a_in, b_in     operands (signed for MIN/MAX)
//   valid_out      FIFO head valid
//   ready_in       consumer pops the head when valid_out && ready_in
//   result_out     head result (0 while empty)
//   error_out      head entry came from an illegal opcode
//   count_out      FIFO occupancy
//
// Optional feature (macro BMU_PERF_CNT_EN)
//   perf_ops_out   saturating count of accepted requests
//   perf_err_out   saturating count of accepted illegal opcodes
// ---------------------------------------------------------------------------
module bmu_op_queue #(
   parameter int XLEN  = 32,
   parameter int DEPTH = 4,
   parameter int OP_W  = 4
) (
   input  logic                         clk,
   input  logic                         rst_l,
   input  logic                         valid_in,
   output logic                         ready_out,
   input  logic [OP_W-1:0]              op_in,
   input  logic                         csr_ren_in,
   input  logic [XLEN-1:0]              csr_rddata_in,
   input  logic [XLEN-1:0]              a_in,
   input  logic [XLEN-1:0]              b_in,
   output logic                         valid_out,
   input  logic                         ready_in,
   output logic [XLEN-1:0]              result_out,
   output logic                         error_out,
   output logic [$clog2(DEPTH+1)-1:0]   count_out
`ifdef BMU_PERF_CNT_EN
   ,
   output logic [31:0]                  perf_ops_out,
   output logic [31:0]                  perf_err_out
`endif
);

   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int SH_W  = $clog2(XLEN);
   localparam int NB    = XLEN / 8;
   localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(DEPTH);
   localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(DEPTH - 1);

   // ------------------------------------------------------------------
   // Operation helpers
   // ------------------------------------------------------------------
   function automatic logic [XLEN-1:0] f_clz(input logic [XLEN-1:0] a);
      logic [XLEN-1:0] n;
      logic            found;
      n     = '0;
      found = 1'b0;
      for (int i = XLEN - 1; i >= 0; i--) begin
         if (!found) begin
            if (a[i]) found = 1'b1;
            else      n = n + XLEN'(1);
         end
      end
      return n;
   endfunction

   function automatic logic [XLEN-1:0] f_ctz(input logic [XLEN-1:0] a);
      logic [XLEN-1:0] n;
      logic            found;
      n     = '0;
      found = 1'b0;
      for (int i = 0; i < XLEN; i++) begin
         if (!found) begin
            if (a[i]) found = 1'b1;
            else      n = n + XLEN'(1);
         end
      end
      return n;
   endfunction

   function automatic logic [XLEN-1:0] f_cpop(input logic [XLEN-1:0] a);
      logic [XLEN-1:0] n;
      n = '0;
      for (int i = 0; i < XLEN; i++) n = n + XLEN'(a[i]);
      return n;
   endfunction

   // Rotates go through a doubled word so that a shift amount of 0 needs
   // no special case.
   function automatic logic [XLEN-1:0] f_rol(input logic [XLEN-1:0] a,
                                             input logic [SH_W-1:0] sh);
      logic [2*XLEN-1:0] t;
      t = {a, a} << sh;
      return t[2*XLEN-1:XLEN];
   endfunction

   function automatic logic [XLEN-1:0] f_ror(input logic [XLEN-1:0] a,
                                             input logic [SH_W-1:0] sh);
      logic [2*XLEN-1:0] t;
      t = {a, a} >> sh;
      return t[XLEN-1:0];
   endfunction

   function automatic logic [XLEN-1:0] f_rev8(input logic [XLEN-1:0] a);
      logic [XLEN-1:0] r;
      r = '0;
      for (int i = 0; i < NB; i++) r[i*8 +: 8] = a[(NB-1-i)*8 +: 8];
      return r;
   endfunction

   function automatic logic [XLEN-1:0] f_orc_b(input logic [XLEN-1:0] a);
      logic [XLEN-1:0] r;
      r = '0;
      for (int i = 0; i < NB; i++) r[i*8 +: 8] = (|a[i*8 +: 8]) ? 8'hFF : 8'h00;
      return r;
   endfunction

   function automatic logic [PTR_W-1:0] f_next_ptr(input logic [PTR_W-1:0] p);
      return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
   endfunction

   function automatic logic [31:0] f_sat_inc(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

   // ------------------------------------------------------------------
   // Stage p0: execute at accept
   // ------------------------------------------------------------------
   logic signed [XLEN-1:0] a_s;
   logic signed [XLEN-1:0] b_s;
   logic [SH_W-1:0]        shamt;
   logic [31:0]            op_ext;
   logic [XLEN-1:0]        res_p0;
   logic                   err_p0;
   logic                   vld_p0;

   assign a_s    = a_in;
   assign b_s    = b_in;
   assign shamt  = b_in[SH_W-1:0];
   assign op_ext = 32'(op_in);

   always_comb begin
      res_p0 = '0;
      err_p0 = 1'b0;
      if (csr_ren_in) begin
         res_p0 = csr_rddata_in;
      end else begin
         case (op_ext)
            32'd0:   res_p0 = a_in & ~b_in;
            32'd1:   res_p0 = a_in | ~b_in;
            32'd2:   res_p0 = ~(a_in ^ b_in);
            32'd3:   res_p0 = f_clz(a_in);
            32'd4:   res_p0 = f_ctz(a_in);
            32'd5:   res_p0 = f_cpop(a_in);
            32'd6:   res_p0 = f_rol(a_in, shamt);
            32'd7:   res_p0 = f_ror(a_in, shamt);
            32'd8:   res_p0 = (a_s < b_s) ? a_in : b_in;
            32'd9:   res_p0 = (a_s > b_s) ? a_in : b_in;
            32'd10:  res_p0 = (a_in < b_in) ? a_in : b_in;
            32'd11:  res_p0 = (a_in > b_in) ? a_in : b_in;
            32'd12:  res_p0 = {{(XLEN-8){a_in[7]}}, a_in[7:0]};
            32'd13:  res_p0 = {{(XLEN-16){1'b0}}, a_in[15:0]};
            32'd14:  res_p0 = f_rev8(a_in);
            32'd15:  res_p0 = f_orc_b(a_in);
            default: err_p0 = 1'b1;
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Stage p1: result FIFO
   // ------------------------------------------------------------------
   logic [XLEN:0]      mem_p1 [DEPTH];
   logic [PTR_W-1:0]   wr_ptr;
   logic [PTR_W-1:0]   rd_ptr;
   logic [CNT_W-1:0]   count;
   logic               pop;
   logic [XLEN:0]      head_p1;

   // ready_out depends only on the registered count, never on ready_in.
   assign ready_out = (count < DEPTH_C);
   assign valid_out = (count != '0);
   assign vld_p0    = valid_in && ready_out;
   assign pop       = valid_out && ready_in;

   always_ff @(posedge clk) begin
      if (rst_l) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (vld_p0) wr_ptr <= f_next_ptr(wr_ptr);
         if (pop)    rd_ptr <= f_next_ptr(rd_ptr);
         case ({vld_p0, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage is not reset: entries are only observable through valid_out.
   always_ff @(posedge clk) begin
      if (vld_p0) mem_p1[wr_ptr] <= {err_p0, res_p0};
   end

   assign head_p1    = mem_p1[rd_ptr];
   // Gate the head so the outputs read as zero whenever the FIFO is empty.
   assign result_out = valid_out ? head_p1[XLEN-1:0] : '0;
   assign error_out  = valid_out ? head_p1[XLEN]     : 1'b0;
   assign count_out  = count;

`ifdef BMU_PERF_CNT_EN
   logic [31:0] perf_ops;
   logic [31:0] perf_err;

   always_ff @(posedge clk) begin
      if (rst_l) begin
         perf_ops <= '0;
         perf_err <= '0;
      end else if (vld_p0) begin
         perf_ops <= f_sat_inc(perf_ops);
         if (err_p0) perf_err <= f_sat_inc(perf_err);
      end
   end

   assign perf_ops_out = perf_ops;
   assign perf_err_out = perf_err;
`endif

endmodule

// File: tb/tb_bmu_op_queue.sv
// Testbench for bmu_op_queue (XLEN=32, DEPTH=4, OP_W=4).
// The stimulus process drives requests. A monitor samples on the falling
// edge: it records accepted requests into an expected queue and checks every
// popped head against that queue.
module tb_bmu_op_queue;

   logic        clk = 1'b0;
   logic        rst_l;
   logic        valid_in;
   logic        ready_out;
   logic [3:0]  op_in;
   logic        csr_ren_in;
   logic [31:0] csr_rddata_in;
   logic [31:0] a_in;
   logic [31:0] b_in;
   logic        valid_out;
   logic        ready_in;
   logic [31:0] result_out;
   logic        error_out;
   logic [2:0]  count_out;
`ifdef BMU_PERF_CNT_EN
   logic [31:0] perf_ops_out;
   logic [31:0] perf_err_out;
`endif

   always #5 clk = ~clk;

   bmu_op_queue #(.XLEN(32), .DEPTH(4), .OP_W(4)) dut (
      .clk           (clk),
      .rst_l         (rst_l),
      .valid_in      (valid_in),
      .ready_out     (ready_out),
      .op_in         (op_in),
      .csr_ren_in    (csr_ren_in),
      .csr_rddata_in (csr_rddata_in),
      .a_in          (a_in),
      .b_in          (b_in),
      .valid_out     (valid_out),
      .ready_in      (ready_in),
      .result_out    (result_out),
      .error_out     (error_out),
      .count_out     (count_out)
`ifdef BMU_PERF_CNT_EN
      ,
      .perf_ops_out  (perf_ops_out),
      .perf_err_out  (perf_err_out)
`endif
   );

   int errors = 0;
   int checks = 0;
   logic [32:0] exp_q[$];
   logic        dir_use = 1'b0;
   logic [32:0] dir_val = '0;
   int          exp_ops = 0;
   int          exp_err = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model, written directly from the opcode table; returns {error, result}.
   function automatic logic [32:0] model(input int op, input logic [31:0] a,
                                         input logic [31:0] b, input logic csr,
                                         input logic [31:0] cd);
      logic [63:0] t;
      int          n;
      int          s;
      int signed   sa;
      int signed   sb;
      logic [31:0] r;
      s  = int'(b[4:0]);
      sa = a;
      sb = b;
      r  = '0;
      if (csr) return {1'b0, cd};
      case (op)
         0:  r = a & ~b;
         1:  r = a | ~b;
         2:  r = ~(a ^ b);
         3:  begin n = 0; while (n < 32 && a[31-n] == 1'b0) n++; r = n; end
         4:  begin n = 0; while (n < 32 && a[n] == 1'b0) n++; r = n; end
         5:  r = $countones(a);
         6:  begin t = {32'b0, a} << s; r = t[31:0] | t[63:32]; end
         7:  begin t = {a, 32'b0} >> s; r = t[63:32] | t[31:0]; end
         8:  r = (sa < sb) ? a : b;
         9:  r = (sa > sb) ? a : b;
         10: r = (a < b) ? a : b;
         11: r = (a > b) ? a : b;
         12: r = (a[7] ? 32'hFFFF_FF00 : 32'h0) | {24'b0, a[7:0]};
         13: r = {16'b0, a[15:0]};
         14: r = {a[7:0], a[15:8], a[23:16], a[31:24]};
         15: for (int k = 0; k < 4; k++) r[k*8 +: 8] = (a[k*8 +: 8] != 0) ? 8'hFF : 8'h00;
         default: return {1'b1, 32'b0};
      endcase
      return {1'b0, r};
   endfunction

   // Monitor: check occupancy/handshake every cycle, score pops, record pushes.
   always @(negedge clk) begin
      logic [32:0] e;
      if (rst_l) begin
         exp_q.delete();
         exp_ops = 0;
         exp_err = 0;
      end else begin
         chk("count_out", 64'(count_out), 64'(exp_q.size()));
         chk("ready_out", 64'(ready_out), 64'(exp_q.size() < 4));
         chk("valid_out", 64'(valid_out), 64'(exp_q.size() != 0));
`ifdef BMU_PERF_CNT_EN
         chk("perf_ops", 64'(perf_ops_out), 64'(exp_ops));
         chk("perf_err", 64'(perf_err_out), 64'(exp_err));
`endif
         if (valid_out && ready_in) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_pop", 64'(valid_out), 64'(0));
            end else begin
               e = exp_q.pop_front();
               chk("head", 64'({error_out, result_out}), 64'(e));
            end
         end
         if (valid_in && ready_out) begin
            e = dir_use ? dir_val : model(int'(op_in), a_in, b_in, csr_ren_in, csr_rddata_in);
            exp_q.push_back(e);
            exp_ops++;
            if (e[32]) exp_err++;
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send_exp(input int op, input logic [31:0] a, input logic [31:0] b,
                           input logic csr, input logic [31:0] cd, input logic [31:0] exp);
      valid_in      = 1'b1;
      op_in         = 4'(op);
      a_in          = a;
      b_in          = b;
      csr_ren_in    = csr;
      csr_rddata_in = cd;
      dir_use       = 1'b1;
      dir_val       = {1'b0, exp};
      step();
      valid_in = 1'b0;
      dir_use  = 1'b0;
   endtask

   function automatic logic [31:0] rand_word();
      case ($urandom_range(0, 5))
         0:       return 32'h0;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'h8000_0000;
         default: return $urandom;
      endcase
   endfunction

   task automatic drive_random(input logic vld);
      valid_in      = vld;
      op_in         = 4'($urandom_range(0, 15));
      a_in          = rand_word();
      b_in          = rand_word();
      csr_ren_in    = ($urandom_range(0, 9) == 0);
      csr_rddata_in = $urandom;
   endtask

   initial begin
      int waited;
      rst_l = 1'b1; valid_in = 1'b0; ready_in = 1'b0; op_in = '0;
      csr_ren_in = 1'b0; csr_rddata_in = '0; a_in = '0; b_in = '0;
      repeat (2) step();
      @(negedge clk);
      chk("rst_valid_out", 64'(valid_out), 64'(0));
      chk("rst_count_out", 64'(count_out), 64'(0));
      chk("rst_ready_out", 64'(ready_out), 64'(1));
      chk("rst_result_out", 64'(result_out), 64'(0));
      chk("rst_error_out", 64'(error_out), 64'(0));
      step();
      rst_l = 1'b0;
      ready_in = 1'b1;

      // Known-answer vectors, drained as they arrive.
      send_exp(0,  32'hF0F0_FFFF, 32'h0000_FFFF, 1'b0, 32'h0, 32'hF0F0_0000);
      send_exp(3,  32'h0,         32'h0,         1'b0, 32'h0, 32'd32);
      send_exp(4,  32'h0000_0100, 32'h0,         1'b0, 32'h0, 32'd8);
      send_exp(5,  32'hFFFF_0000, 32'h0,         1'b0, 32'h0, 32'd16);
      send_exp(7,  32'h0000_0001, 32'h1,         1'b0, 32'h0, 32'h8000_0000);
      send_exp(8,  32'hFFFF_FFFF, 32'h1,         1'b0, 32'h0, 32'hFFFF_FFFF);
      send_exp(3,  32'h1234_5678, 32'h0,         1'b1, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
      send_exp(14, 32'h1122_3344, 32'h0,         1'b0, 32'h0, 32'h4433_2211);
      send_exp(12, 32'h0000_0080, 32'h0,         1'b0, 32'h0, 32'hFFFF_FF80);
      send_exp(15, 32'h0100_0020, 32'h0,         1'b0, 32'h0, 32'hFF00_00FF);
      repeat (3) step();

      // Fill with no consumer: five offered, four taken.
      ready_in = 1'b0;
      for (int i = 0; i < 5; i++) begin
         drive_random(1'b1);
         step();
      end
      valid_in = 1'b0;
      @(negedge clk);
      chk("full_count_out", 64'(count_out), 64'(4));
      chk("full_ready_out", 64'(ready_out), 64'(0));
      step();

      // Push and pop together while full, so the pointers wrap.
      ready_in = 1'b1;
      for (int i = 0; i < 6; i++) begin
         drive_random(1'b1);
         step();
      end
      valid_in = 1'b0;
      repeat (6) step();

      // Reset with three entries queued and a request in flight.
      ready_in = 1'b0;
      for (int i = 0; i < 3; i++) begin
         drive_random(1'b1);
         step();
      end
      rst_l = 1'b1;
      drive_random(1'b1);
      step();
      rst_l = 1'b0;
      valid_in = 1'b0;
      @(negedge clk);
      chk("midrst_count_out", 64'(count_out), 64'(0));
      chk("midrst_valid_out", 64'(valid_out), 64'(0));
      step();

      // Random traffic with random back-pressure.
      for (int i = 0; i < 400; i++) begin
         drive_random($urandom_range(0, 3) != 0);
         ready_in = ($urandom_range(0, 2) != 0);
         step();
      end

      // Drain, bounded.
      valid_in = 1'b0;
      ready_in = 1'b1;
      waited = 0;
      while (exp_q.size() != 0 && waited < 20) begin
         step();
         waited++;
      end
      if (exp_q.size() != 0) begin
         errors++;
         checks++;
         $display("FAIL drain_timeout: %0d entries left, expected 0", exp_q.size());
      end
      step();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
